// File: rtl/sb_pkg.sv
// Shared sideband definitions used by the RX pattern detector and the TX pattern generator.
package sb_pkg;

    // One full SBINIT clock-pattern word: alternating 1/0 starting with 1 in the MSB.
    localparam logic [63:0] SB_CLK_PATTERN        = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam int          SB_CYCLES_PER_MS      = 100;
    localparam int          SB_PATTERN_TIMEOUT_MS = 8;

    // Converts a duration in milliseconds to block clock cycles.
    function automatic int sb_ms_to_cycles(input int ms);
        return ms * SB_CYCLES_PER_MS;
    endfunction

    localparam int SB_PATTERN_TIMEOUT_CYCLES = sb_ms_to_cycles(SB_PATTERN_TIMEOUT_MS);

    typedef enum logic [1:0] {
        SB_DET_IDLE    = 2'd0,
        SB_DET_SEARCH  = 2'd1,
        SB_DET_DONE    = 2'd2,
        SB_DET_TIMEOUT = 2'd3
    } sb_det_state_e;

endpackage

// File: rtl/sb_pattern_cmp.sv
// Combinational compare of one deserialized word against the clock pattern and its inverse.
module sb_pattern_cmp
    import sb_pkg::*;
#(
    parameter int                WORD_W     = 64,
    parameter logic [WORD_W-1:0] PATTERN    = SB_CLK_PATTERN,
    parameter bit                ACCEPT_INV = 1'b1
) (
    input  logic [WORD_W-1:0] data,
    output logic              hit,
    output logic              phase
);

    logic match_norm;
    logic match_inv;

    // Phase is 1 only for a pure inverted match; a normal match always reports phase 0.
    always_comb begin
        match_norm = (data == PATTERN);
        match_inv  = ACCEPT_INV && (data == ~PATTERN);
        hit        = match_norm | match_inv;
        phase      = ~match_norm & match_inv;
    end

endmodule

// File: rtl/sb_rx_pattern_det.sv
// Sideband RX clock-pattern detector: counts consecutive pattern words, reports lock or timeout.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// SB_DET_IDLE    | detection not requested; counters, timer and phase cleared
// SB_DET_SEARCH  | timer running, counting consecutive same-phase pattern words
// SB_DET_DONE    | lock reached; locked level high, strobes ignored
// SB_DET_TIMEOUT | window expired without lock; strobes ignored
module sb_rx_pattern_det
    import sb_pkg::*;
#(
    parameter int                WORD_W         = 64,
    parameter logic [WORD_W-1:0] PATTERN        = SB_CLK_PATTERN,
    parameter int                REQ_MATCHES    = 2,
    parameter int                TIMEOUT_CYCLES = SB_PATTERN_TIMEOUT_CYCLES,
    parameter bit                ACCEPT_INV     = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start_detect,
    input  logic [WORD_W-1:0] i_de_ser_data,
    input  logic              i_de_ser_done,
    output logic              o_rx_sb_pattern_samp_done,
    output logic              o_pattern_locked,
    output logic              o_pattern_time_out,
    output logic [3:0]        o_match_cnt
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         REQ_CNT    = 4'(REQ_MATCHES);

    sb_det_state_e      state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         match_cnt_q, match_cnt_d;
    logic               phase_q, phase_d;
    logic               samp_done_q, samp_done_d;
    logic               time_out_q, time_out_d;

    logic               word_hit;
    logic               word_phase;
    logic [3:0]         hit_cnt;

    sb_pattern_cmp #(
        .WORD_W     (WORD_W),
        .PATTERN    (PATTERN),
        .ACCEPT_INV (ACCEPT_INV)
    ) u_cmp (
        .data  (i_de_ser_data),
        .hit   (word_hit),
        .phase (word_phase)
    );

    // Count a hit would produce: same phase extends the run (saturating), a phase flip restarts at 1.
    always_comb begin
        hit_cnt = 4'd1;
        if (word_phase == phase_q) begin
            hit_cnt = (match_cnt_q < REQ_CNT) ? match_cnt_q + 4'd1 : match_cnt_q;
        end
    end

    // Next-state, counter and pulse decode; dropping start has priority over everything else.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        match_cnt_d = match_cnt_q;
        phase_d     = phase_q;
        samp_done_d = 1'b0;
        time_out_d  = 1'b0;

        if (!i_start_detect) begin
            state_d     = SB_DET_IDLE;
            timer_d     = '0;
            match_cnt_d = '0;
            phase_d     = 1'b0;
        end else begin
            case (state_q)
                SB_DET_IDLE: begin
                    state_d     = SB_DET_SEARCH;
                    timer_d     = '0;
                    match_cnt_d = '0;
                    phase_d     = 1'b0;
                end
                SB_DET_SEARCH: begin
                    // Timer saturates at its terminal value; the state leaves SEARCH there anyway.
                    if (timer_q != TIMER_LAST) begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                    if (i_de_ser_done) begin
                        if (word_hit) begin
                            match_cnt_d = hit_cnt;
                            phase_d     = word_phase;
                        end else begin
                            match_cnt_d = '0;
                        end
                    end
                    // Lock is checked first so a lock on the terminal cycle beats the timeout.
                    if (i_de_ser_done && word_hit && (hit_cnt == REQ_CNT)) begin
                        state_d     = SB_DET_DONE;
                        samp_done_d = 1'b1;
                    end else if (timer_q == TIMER_LAST) begin
                        state_d    = SB_DET_TIMEOUT;
                        time_out_d = 1'b1;
                    end
                end
                SB_DET_DONE: begin
                    state_d = SB_DET_DONE;
                end
                SB_DET_TIMEOUT: begin
                    state_d = SB_DET_TIMEOUT;
                end
                default: begin
                    state_d = SB_DET_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered pulses; async reset clears everything with no release pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= SB_DET_IDLE;
            timer_q     <= '0;
            match_cnt_q <= '0;
            phase_q     <= 1'b0;
            samp_done_q <= 1'b0;
            time_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            match_cnt_q <= match_cnt_d;
            phase_q     <= phase_d;
            samp_done_q <= samp_done_d;
            time_out_q  <= time_out_d;
        end
    end

    assign o_rx_sb_pattern_samp_done = samp_done_q;
    assign o_pattern_time_out        = time_out_q;
    assign o_pattern_locked          = (state_q == SB_DET_DONE);
    assign o_match_cnt               = match_cnt_q;

endmodule

// File: tb/tb_sb_rx_pattern_det.sv
// Directed scoreboard bench for the sideband RX clock-pattern detector.
module tb_sb_rx_pattern_det;

    localparam logic [63:0] PAT  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] INV  = 64'h5555_5555_5555_5555;
    localparam logic [63:0] ZERO = 64'h0000_0000_0000_0000;

    typedef struct {
        string      tag;
        logic [3:0] cnt;
        logic       samp;
        logic       lock;
        logic       tout;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] data;
    logic        dv;
    logic        samp_done;
    logic        locked;
    logic        time_out;
    logic [3:0]  match_cnt;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    sb_rx_pattern_det dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_start_detect            (start),
        .i_de_ser_data             (data),
        .i_de_ser_done             (dv),
        .o_rx_sb_pattern_samp_done (samp_done),
        .o_pattern_locked          (locked),
        .o_pattern_time_out        (time_out),
        .o_match_cnt               (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] c, input logic s, input logic l,
                        input logic t);
        exp_t e;
        e.tag  = tag;
        e.cnt  = c;
        e.samp = s;
        e.lock = l;
        e.tout = t;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (match_cnt === e.cnt) else begin
                errors++;
                $error("FAIL %s match_cnt: observed %0d expected %0d", e.tag, match_cnt, e.cnt);
            end
            checks++;
            assert (samp_done === e.samp) else begin
                errors++;
                $error("FAIL %s samp_done: observed %0b expected %0b", e.tag, samp_done, e.samp);
            end
            checks++;
            assert (locked === e.lock) else begin
                errors++;
                $error("FAIL %s locked: observed %0b expected %0b", e.tag, locked, e.lock);
            end
            checks++;
            assert (time_out === e.tout) else begin
                errors++;
                $error("FAIL %s time_out: observed %0b expected %0b", e.tag, time_out, e.tout);
            end
        end
    endtask

    // Drive one cycle of stimulus, record what the following cycle must show, then compare.
    task automatic cyc(input logic st, input logic v, input logic [63:0] d, input string tag,
                       input logic [3:0] c, input logic s, input logic l, input logic t);
        start = st;
        dv    = v;
        data  = d;
        push(tag, c, s, l, t);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic quiet(input int n, input logic st, input string tag, input logic [3:0] c,
                         input logic l);
        for (int i = 0; i < n; i++) begin
            cyc(st, 1'b0, ZERO, tag, c, 1'b0, l, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        dv     = 1'b0;
        data   = ZERO;

        #3;
        push("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        check_pop();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, ZERO, "rst_release", 4'd0, 1'b0, 1'b0, 1'b0);

        // Two pattern words on cycles 5 and 9 after start.
        cyc(1'b1, 1'b1, PAT, "t1_start_ign", 4'd0, 1'b0, 1'b0, 1'b0);
        quiet(4, 1'b1, "t1_wait", 4'd0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t1_hit1", 4'd1, 1'b0, 1'b0, 1'b0);
        quiet(3, 1'b1, "t1_hold", 4'd1, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t1_lock", 4'd2, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, ZERO, "t1_after", 4'd2, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, ZERO, "t1_done_ign", 4'd2, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, ZERO, "t1_drop", 4'd0, 1'b0, 1'b0, 1'b0);

        // Miss in the middle restarts the run.
        cyc(1'b1, 1'b0, ZERO, "t2_start", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t2_s1", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, ZERO, "t2_s2_miss", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t2_s3", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t2_s4_lock", 4'd2, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, ZERO, "t2_drop", 4'd0, 1'b0, 1'b0, 1'b0);

        // Phase change to the inverted pattern restarts at 1, then locks in that phase.
        cyc(1'b1, 1'b0, ZERO, "t3_start", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t3_norm", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, INV, "t3_flip", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, INV, "t3_inv_lock", 4'd2, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, ZERO, "t3_drop", 4'd0, 1'b0, 1'b0, 1'b0);

        // Start drop mid-search clears the count; re-assert restarts from zero.
        cyc(1'b1, 1'b0, ZERO, "t6_start", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t6_hit", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, ZERO, "t6_drop", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, ZERO, "t6_restart", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t6_fresh_hit", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, PAT, "t6_drop_vs_lock", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, ZERO, "t6_no_late_pulse", 4'd0, 1'b0, 1'b0, 1'b0);

        // Only non-pattern strobes: timeout pulse 800 cycles after start.
        cyc(1'b1, 1'b0, ZERO, "t4_start", 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 800; i++) begin
            cyc(1'b1, 1'b1, ZERO, "t4_search", 4'd0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1, ZERO, "t4_timeout", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, PAT, "t4_after_ign", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t4_still_out", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, ZERO, "t4_drop", 4'd0, 1'b0, 1'b0, 1'b0);

        // Second hit lands on the terminal timer cycle: lock wins.
        cyc(1'b1, 1'b0, ZERO, "t5_start", 4'd0, 1'b0, 1'b0, 1'b0);
        quiet(4, 1'b1, "t5_wait", 4'd0, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t5_hit1", 4'd1, 1'b0, 1'b0, 1'b0);
        quiet(794, 1'b1, "t5_hold", 4'd1, 1'b0);
        cyc(1'b1, 1'b1, PAT, "t5_lock_at_last", 4'd2, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, ZERO, "t5_after", 4'd2, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, ZERO, "t5_drop", 4'd0, 1'b0, 1'b0, 1'b0);

        // Async reset while locked; start stays high through release.
        cyc(1'b1, 1'b0, ZERO, "t7_start", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, INV, "t7_hit1", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, INV, "t7_lock", 4'd2, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, ZERO, "t7_locked", 4'd2, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        push("t7_async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
        check_pop();
        @(posedge clk);
        #1;
        push("t7_rst_held", 4'd0, 1'b0, 1'b0, 1'b0);
        check_pop();
        rst = 1'b0;
        cyc(1'b1, 1'b0, ZERO, "t7_release1", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, ZERO, "t7_release2", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, ZERO, "t7_drop", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
